// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: latches decoded instruction state, drives ALU operands and op with priority forwarding.
// Latency: 1 cycle from ID acceptance to EX outputs; one instruction per cycle when EX keeps ex_ready high.
// Backpressure: holds while ex_valid & ~ex_ready, capturing forwarded operands so a stall never loses them.
//
// Ports: clk/rst (async active-high); id_valid/id_ready with instr, reg_data1/2, pcs from ID;
//        flush squashes both stages; fwd_data/fwd_a_sel/fwd_b_sel forwarding sources (index 0 youngest);
//        ex_valid/ex_ready handshake toward EX with ex_instr, alu_a, alu_b, alu_op.
module alu_operand_stage #(
    parameter int WIDTH   = 16,
    parameter int NUM_FWD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic                     flush,
    input  logic [15:0]              instr,
    input  logic [WIDTH-1:0]         reg_data1,
    input  logic [WIDTH-1:0]         reg_data2,
    input  logic [WIDTH-1:0]         pcs,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_a_sel,
    input  logic [NUM_FWD-1:0]       fwd_b_sel,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [15:0]              ex_instr,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [6:0]               alu_op
);

    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_PCS    = 4'b1110;

    // Stored stage state
    logic             valid_q;
    logic [15:0]      instr_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    logic [WIDTH-1:0] pcs_q;
    logic             cap_a;
    logic             cap_b;

    // Decode of the stored instruction
    logic [1:0]       out_sel;
    logic             sat;
    logic             red;
    logic             sub;
    logic [1:0]       shiftop;
    logic             b_imm;
    logic             is_pcs;
    logic [WIDTH-1:0] imm;

    // Forwarding
    logic [WIDTH-1:0] fwd_a_val;
    logic [WIDTH-1:0] fwd_b_val;
    logic             a_reg_src;
    logic             b_reg_src;
    logic             fwd_a_hit;
    logic             fwd_b_hit;
    logic [WIDTH-1:0] rs_res;
    logic [WIDTH-1:0] rt_res;

    logic             load;

    assign id_ready = ~flush & (~valid_q | ex_ready);
    assign load     = id_valid & id_ready;

    always_comb begin
        out_sel = 2'b00;
        sat     = 1'b0;
        red     = 1'b0;
        sub     = 1'b0;
        shiftop = 2'b00;
        b_imm   = 1'b0;
        is_pcs  = 1'b0;
        imm     = '0;
        unique case (instr_q[15:12])
            OP_SUB:    sub = 1'b1;
            OP_RED:    red = 1'b1;
            OP_XOR:    out_sel = 2'b01;
            OP_PADDSB: sat = 1'b1;
            OP_SLL, OP_SRA, OP_ROR: begin
                out_sel = 2'b10;
                shiftop = instr_q[1:0];
                b_imm   = 1'b1;
                imm     = WIDTH'($signed(instr_q[3:0]));
            end
            OP_LW, OP_SW: begin
                // Halfword-addressed offset: the nibble counts 2-byte units
                b_imm = 1'b1;
                imm   = WIDTH'($signed({instr_q[3:0], 1'b0}));
            end
            OP_LHB: begin
                b_imm = 1'b1;
                imm   = WIDTH'({instr_q[7:0], 8'h00});
            end
            OP_LLB: begin
                b_imm = 1'b1;
                imm   = WIDTH'(instr_q[7:0]);
            end
            OP_PCS:  is_pcs = 1'b1;
            default: ;  // ADD, branches, HLT: both operands from registers
        endcase
    end

    // Priority pick: scan from oldest to youngest so the lowest set index wins
    always_comb begin
        fwd_a_val = '0;
        fwd_b_val = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_a_sel[i]) fwd_a_val = fwd_data[i*WIDTH +: WIDTH];
            if (fwd_b_sel[i]) fwd_b_val = fwd_data[i*WIDTH +: WIDTH];
        end
    end

    assign a_reg_src = ~is_pcs;
    assign b_reg_src = ~is_pcs & ~b_imm;

    // Once captured, the stored value is already the producer's result
    assign fwd_a_hit = a_reg_src & ~cap_a & (|fwd_a_sel);
    assign fwd_b_hit = b_reg_src & ~cap_b & (|fwd_b_sel);

    assign rs_res = fwd_a_hit ? fwd_a_val : rs_q;
    assign rt_res = fwd_b_hit ? fwd_b_val : rt_q;

    assign ex_valid = valid_q;
    assign ex_instr = instr_q;
    assign alu_op   = {out_sel, sat, red, sub, shiftop};
    assign alu_a    = is_pcs ? '0 : rs_res;
    // Subtract is A + ~B + 1; the ALU provides the +1 as carry-in
    assign alu_b    = is_pcs ? pcs_q :
                      b_imm  ? imm   :
                      sub    ? ~rt_res : rt_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            pcs_q   <= '0;
            cap_a   <= 1'b0;
            cap_b   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= instr;
            rs_q    <= reg_data1;
            rt_q    <= reg_data2;
            pcs_q   <= pcs;
            cap_a   <= 1'b0;
            cap_b   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (valid_q & ex_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled: freeze a forwarded result that may disappear next cycle.
            // rt is stored un-inverted; SUB inversion is applied at the output.
            if (fwd_a_hit) begin
                rs_q  <= fwd_a_val;
                cap_a <= 1'b1;
            end
            if (fwd_b_hit) begin
                rt_q  <= fwd_b_val;
                cap_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    localparam int W  = 16;
    localparam int NF = 2;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic            id_ready;
    logic            flush;
    logic [15:0]     instr;
    logic [W-1:0]    reg_data1;
    logic [W-1:0]    reg_data2;
    logic [W-1:0]    pcs;
    logic [NF*W-1:0] fwd_data;
    logic [NF-1:0]   fwd_a_sel;
    logic [NF-1:0]   fwd_b_sel;
    logic            ex_valid;
    logic            ex_ready;
    logic [15:0]     ex_instr;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [6:0]      alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_stage #(.WIDTH(W), .NUM_FWD(NF)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .flush     (flush),
        .instr     (instr),
        .reg_data1 (reg_data1),
        .reg_data2 (reg_data2),
        .pcs       (pcs),
        .fwd_data  (fwd_data),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_instr  (ex_instr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what instruction the EX slot holds and the operand values it will present
    logic         m_valid;
    logic [15:0]  m_instr;
    logic [W-1:0] m_rs;
    logic [W-1:0] m_rt;
    logic [W-1:0] m_pcs;
    logic         m_frozen_a;
    logic         m_frozen_b;

    task automatic model_reset();
        m_valid = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_pcs = 0;
        m_frozen_a = 0; m_frozen_b = 0;
    endtask

    // Operand B source class: 0 register, 1 immediate, 2 PC+2
    function automatic int b_kind(input logic [15:0] ins);
        case (ins[15:12])
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: return 1;
            4'hE:                                      return 2;
            default:                                   return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] imm_of(input logic [15:0] ins);
        int nib;
        nib = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        case (ins[15:12])
            4'h4, 4'h5, 4'h6: return W'(nib);
            4'h8, 4'h9:       return W'(nib * 2);
            4'hA:             return W'(int'(ins[7:0]) * 256);
            default:          return W'(int'(ins[7:0]));
        endcase
    endfunction

    function automatic logic [6:0] op_of(input logic [15:0] ins);
        case (ins[15:12])
            4'h1:             return 7'd4;                    // sub
            4'h2:             return 7'd8;                    // red
            4'h3:             return 7'd32;                   // out_sel XOR
            4'h7:             return 7'd16;                   // sat
            4'h4, 4'h5, 4'h6: return 7'(64 + int'(ins[1:0])); // shifter + shiftop
            default:          return 7'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick(input logic [NF-1:0] sel, input logic [NF*W-1:0] data,
                                          input logic [W-1:0] dflt);
        for (int i = 0; i < NF; i++)
            if (sel[i]) return data[i*W +: W];
        return dflt;
    endfunction

    function automatic logic [W-1:0] exp_a();
        if (m_instr[15:12] == 4'hE) return '0;
        if (!m_frozen_a) return pick(fwd_a_sel, fwd_data, m_rs);
        return m_rs;
    endfunction

    function automatic logic [W-1:0] resolved_rt();
        if (!m_frozen_b) return pick(fwd_b_sel, fwd_data, m_rt);
        return m_rt;
    endfunction

    function automatic logic [W-1:0] exp_b();
        case (b_kind(m_instr))
            1:       return imm_of(m_instr);
            2:       return m_pcs;
            default: return (m_instr[15:12] == 4'h1) ? ~resolved_rt() : resolved_rt();
        endcase
    endfunction

    task automatic model_check();
        logic exp_rdy;
        exp_rdy = !flush && (!m_valid || ex_ready);
        check("id_ready", 32'(id_ready), 32'(exp_rdy));
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid) begin
            check("ex_instr", 32'(ex_instr), 32'(m_instr));
            check("alu_a", 32'(alu_a), 32'(exp_a()));
            check("alu_b", 32'(alu_b), 32'(exp_b()));
            check("alu_op", 32'(alu_op), 32'(op_of(m_instr)));
        end
    endtask

    task automatic model_step();
        logic accept;
        accept = id_valid && !flush && (!m_valid || ex_ready);
        if (accept) begin
            m_valid = 1; m_instr = instr; m_rs = reg_data1; m_rt = reg_data2; m_pcs = pcs;
            m_frozen_a = 0; m_frozen_b = 0;
        end else if (flush || (m_valid && ex_ready)) begin
            m_valid = 0;
        end else if (m_valid) begin
            if (m_instr[15:12] != 4'hE && !m_frozen_a && fwd_a_sel != 0) begin
                m_rs = pick(fwd_a_sel, fwd_data, m_rs);
                m_frozen_a = 1;
            end
            if (b_kind(m_instr) == 0 && !m_frozen_b && fwd_b_sel != 0) begin
                m_rt = pick(fwd_b_sel, fwd_data, m_rt);
                m_frozen_b = 1;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [15:0] ins, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] p, input logic rdy);
        id_valid = v; instr = ins; reg_data1 = d1; reg_data2 = d2; pcs = p; ex_ready = rdy;
    endtask

    task automatic clear_fwd();
        fwd_a_sel = '0; fwd_b_sel = '0; fwd_data = '0;
    endtask

    initial begin
        rst = 1; flush = 0;
        set_in(0, 16'h0, '0, '0, '0, 0);
        clear_fwd();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset ex_valid", 32'(ex_valid), 32'h0);
        check("reset alu_a", 32'(alu_a), 32'h0);
        check("reset alu_b", 32'(alu_b), 32'h0);
        check("reset alu_op", 32'(alu_op), 32'h0);
        check("reset ex_instr", 32'(ex_instr), 32'h0);
        rst = 0;
        @(negedge clk);

        // ADD with operand A forwarded from source 0
        set_in(1, 16'h0123, 16'd5, 16'd7, '0, 1); settle(); advance();
        set_in(0, 16'h0, '0, '0, '0, 1);
        fwd_a_sel = 2'b01; fwd_data = {16'h0000, 16'h00AA};
        settle();
        check("add alu_a", 32'(alu_a), 32'h00AA);
        check("add alu_b", 32'(alu_b), 32'h0007);
        check("add alu_op", 32'(alu_op), 32'h0);
        advance();
        clear_fwd();

        // SUB, both sources request B: source 0 wins, then inverted
        set_in(1, 16'h1123, 16'd1, 16'h0003, '0, 1); settle(); advance();
        set_in(0, 16'h0, '0, '0, '0, 1);
        fwd_b_sel = 2'b11; fwd_data = {16'h0020, 16'h0010};
        settle();
        check("sub alu_b", 32'(alu_b), 32'hFFEF);
        check("sub alu_op", 32'(alu_op), 32'h04);
        advance();
        clear_fwd();

        // Immediate forms back to back; forward requests must be ignored for them
        set_in(1, 16'h812E, 16'h1111, 16'h2222, '0, 1); settle(); advance();
        set_in(1, 16'hA1AB, 16'h3333, 16'h4444, '0, 1);
        fwd_b_sel = 2'b01; fwd_data = {16'h5555, 16'h6666};
        settle();
        check("lw alu_b", 32'(alu_b), 32'hFFFC);
        advance();
        set_in(1, 16'hE100, 16'h7777, 16'h8888, 16'h0042, 1);
        settle();
        check("lhb alu_b", 32'(alu_b), 32'hAB00);
        advance();
        set_in(0, 16'h0, '0, '0, '0, 1);
        fwd_a_sel = 2'b11; fwd_b_sel = 2'b11;
        settle();
        check("pcs alu_a", 32'(alu_a), 32'h0000);
        check("pcs alu_b", 32'(alu_b), 32'h0042);
        advance();
        clear_fwd();

        // Stall capture: forwarded value survives the source going away
        set_in(1, 16'h0123, 16'd5, 16'd7, '0, 1); settle(); advance();
        set_in(1, 16'h3456, 16'd9, 16'd9, '0, 0);
        fwd_a_sel = 2'b01; fwd_data = {16'h0000, 16'h1234};
        settle();
        check("stall1 alu_a", 32'(alu_a), 32'h1234);
        check("stall1 id_ready", 32'(id_ready), 32'h0);
        advance();
        fwd_a_sel = 2'b00; fwd_data = {16'h0000, 16'hFFFF};
        settle();
        check("stall2 alu_a", 32'(alu_a), 32'h1234);
        check("stall2 id_ready", 32'(id_ready), 32'h0);
        advance();
        fwd_a_sel = 2'b01;
        ex_ready = 1; id_valid = 0;
        settle();
        check("stall release alu_a", 32'(alu_a), 32'h1234);
        advance();
        clear_fwd();

        // Flush during stall with a pending ID instruction
        set_in(1, 16'h0123, 16'd1, 16'd2, '0, 1); settle(); advance();
        set_in(0, 16'h0, '0, '0, '0, 0); settle(); advance();
        set_in(1, 16'h3000, 16'hAAAA, 16'h5555, '0, 0);
        flush = 1;
        settle();
        check("flush id_ready", 32'(id_ready), 32'h0);
        advance();
        flush = 0;
        settle();
        check("post-flush ex_valid", 32'(ex_valid), 32'h0);
        check("post-flush id_ready", 32'(id_ready), 32'h1);
        advance();
        id_valid = 0;
        settle();
        check("reload ex_valid", 32'(ex_valid), 32'h1);
        check("reload ex_instr", 32'(ex_instr), 32'h3000);
        advance();

        // Back-to-back stream, one instruction per cycle in order
        for (int k = 0; k < 4; k++) begin
            set_in(1, 16'(16'h3010 + k), 16'(k), 16'(k + 1), '0, 1);
            settle();
            if (k > 0) check("b2b ex_instr", 32'(ex_instr), 32'(16'h3010 + k - 1));
            advance();
        end
        set_in(0, 16'h0, '0, '0, '0, 0);
        settle();
        check("b2b last", 32'(ex_instr), 32'h3013);
        advance();

        // Reset while an instruction is stalled
        fwd_a_sel = 2'b01; fwd_data = {16'h0000, 16'hBEEF};
        settle(); advance();
        clear_fwd();
        rst = 1;
        #1;
        check("midrst ex_valid", 32'(ex_valid), 32'h0);
        check("midrst alu_a", 32'(alu_a), 32'h0);
        check("midrst alu_b", 32'(alu_b), 32'h0);
        check("midrst alu_op", 32'(alu_op), 32'h0);
        check("midrst ex_instr", 32'(ex_instr), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            id_valid  = ($urandom_range(0, 3) != 0);
            instr     = 16'($urandom);
            reg_data1 = W'($urandom);
            reg_data2 = W'($urandom);
            pcs       = W'($urandom);
            ex_ready  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            fwd_a_sel = NF'($urandom);
            fwd_b_sel = NF'($urandom);
            fwd_data  = {16'($urandom), 16'($urandom)};
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Registered ID/EX operand stage for the pipelined CPU. It decodes the 4-bit opcode and latches instruction, register data and PC+2 under a valid/ready handshake. It drives formatted ALU operands and the 7-bit ALU op, with N-deep priority forwarding. Forwarded values are captured while EX is stalled, so a stall never loses a producer's result.

Parameters:
WIDTH, 16, datapath width (>=16)
NUM_FWD, 2, forwarding sources; index 0 = youngest (MEM), highest priority

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_ready  out  1  stage accepts ID this cycle
flush  in  1  squash EX-resident instruction and the incoming one
instr  in  16  instruction word (opcode [15:12])
reg_data1  in  WIDTH  rs read data
reg_data2  in  WIDTH  rt read data
pcs  in  WIDTH  PC+2 of instruction
fwd_data  in  NUM_FWD*WIDTH  source i at [i*WIDTH +: WIDTH]
fwd_a_sel  in  NUM_FWD  per-source forward request, operand A
fwd_b_sel  in  NUM_FWD  per-source forward request, operand B
ex_valid  out  1  EX holds a valid instruction
ex_ready  in  1  EX consumer accepts this cycle
ex_instr  out  16  latched instruction
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_op  out  7  {out_sel[1:0], sat, red, sub, shiftop[1:0]}

Behaviour:
- Reset (async): ex_valid=0. Stored instr, operands and capture flags clear to 0. Outputs are therefore alu_a=0, alu_b=0, alu_op=0, ex_instr=0.
- Handshake: id_ready = ~flush & (~ex_valid | ex_ready). A load happens on id_valid & id_ready.
- On load: latch instr, reg_data1, reg_data2 and pcs, set ex_valid=1, clear cap_a and cap_b. Throughput is 1 instruction/cycle and latency is 1 cycle.
- On ex_valid & ex_ready with no load: ex_valid<=0.
- On ex_valid & ~ex_ready: hold all state.
- flush: ex_valid<=0 next edge, no load that cycle. Flush wins over ex_ready and id_valid.
- Decode by opcode:
  - 0000 ADD, 0001 SUB, 0010 RED, 0011 XOR, 0111 PADDSB: B from register.
  - 0100 SLL, 0101 SRA, 0110 ROR, 1000 LW, 1001 SW, 1010 LHB, 1011 LLB: B from immediate.
  - 1110 PCS: A=0, B=pcs.
  - 1100 B, 1101 BR, 1111 HLT: A=rs path, B=rt path (don't-care to ALU).
- alu_op fields:
  - out_sel: 00=CLA, 01=XOR (0011), 10=shifter (0100-0110).
  - sat=1 for 0111 only. red=1 for 0010 only. sub=1 for 0001 only.
  - shiftop=instr[1:0].
  - All fields are 0 for non-ALU opcodes.
- Immediates:
  - shifts: sign-extended instr[3:0].
  - LW/SW: sign-extended {instr[3:0],1'b0}.
  - LLB: zero-extended instr[7:0].
  - LHB: instr[7:0] in bits [15:8], all other bits 0.
- Forwarding, operand X in {A,B}, register-sourced only:
  - If ~cap_x and fwd_x_sel != 0, the operand is fwd_data of the lowest set index. Otherwise it is the stored value.
  - Immediate-sourced B and PCS A/B ignore fwd_*_sel.
- Stall capture: if ex_valid & ~ex_ready & ~flush & ~cap_x & (fwd_x_sel != 0) on a register-sourced operand:
  - the stored operand takes the forwarded value and cap_x<=1;
  - later fwd_x_sel is ignored until the next load.
- SUB: alu_b is the bitwise inverse of the resolved rt value; the ALU supplies carry-in.
- Outputs are driven combinationally from stored state plus forwarding. They are valid only while ex_valid=1.
- Reset mid-stall discards the held instruction and captured values.

Test Plan:
- ADD (0x0123), reg_data1=5, reg_data2=7, fwd_a_sel=01 with fwd_data[0]=0x00AA -> cycle after load: alu_a=0x00AA, alu_b=0x0007, alu_op=0.
- SUB (0x1123), reg_data2=0x0003, fwd_b_sel=11, src0=0x0010, src1=0x0020 -> alu_b=0xFFEF (src0 wins, inverted), sub=1.
- LW (0x812E), offset -2 -> alu_b=0xFFFC. LHB (0xA1AB) -> alu_b=0xAB00. PCS (0xE100), pcs=0x0042 -> alu_a=0, alu_b=0x0042.
- Stall capture: ADD held with ex_ready=0, fwd_a_sel=01 and src0=0x1234 for 1 cycle, then sel=0, src0=0xFFFF -> alu_a stays 0x1234 until ex_ready=1. id_ready=0 throughout the stall.
- Flush during stall with id_valid=1 -> ex_valid=0 next cycle, no load that cycle. The next instruction loads the following cycle.
- Back-to-back: 4 instructions with ex_ready=1 -> one ex_valid per cycle in order. Asserting rst mid-stream -> ex_valid=0 and outputs 0 immediately.
